rf_write_buffer: RTL and testbench

- Writer-side companion to the 32x32 register file.
- Accepts register write-back requests from the pipeline and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the register file's single write port (we/addr/data). The register file commits that write on the falling edge of the same cycle.
- Provides two read-bypass lookup ports (RS, RT) so readers see pending, not-yet-committed values.

---
 rtl/rf_write_buffer_pkg.sv | 14 +
 rtl/rf_wb_match.sv | 41 ++++
 rtl/rf_write_buffer.sv | 108 ++++++++++
 tb/tb_rf_write_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_buffer_pkg.sv
// Shared definitions for the register-file write buffer.
//   AW, DW   : register address / data width of the 32x32 register file
//   REG_ZERO : address of the hard-wired zero register; writes to it are dropped
//   wb_entry_t : one buffered write-back request {addr, data}
package rf_write_buffer_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_match.sv
// Newest-match bypass search for one read port.
// Ports:
//   entries_i : buffered entries (FIFO storage, indexed by slot)
//   valid_i   : per-slot valid bits
//   tail_i    : next slot to be written; the newest entry is at tail_i-1
//   addr_i    : lookup address
//   hit_o     : addr_i is nonzero and matches a valid entry
//   data_o    : data of the newest matching entry, else 0
module rf_wb_match
  import rf_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t        entries_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [PW-1:0]    tail_i,
  input  logic [AW-1:0]    addr_i,
  output logic             hit_o,
  output logic [DW-1:0]    data_o
);

  // Walk from the oldest slot (tail-DEPTH) to the newest (tail-1); a later
  // match overwrites an earlier one, so the newest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    if (addr_i != REG_ZERO) begin
      for (int k = DEPTH; k >= 1; k--) begin
        idx = tail_i - PW'(k);
        if (valid_i[idx] && (entries_i[idx].addr == addr_i)) begin
          hit_o  = 1'b1;
          data_o = entries_i[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_buffer.sv
// In-order write-back buffer in front of the register file's single write port.
// Requests are queued in a DEPTH-entry FIFO and drained one per cycle; the
// register file commits the drained write on the falling edge of that cycle.
// Two bypass ports expose pending (not yet committed) values to readers.
//
// Handshake: a request transfers at a rising edge when wr_valid_i && wr_ready_o.
// wr_ready_o depends only on the registered count, so a full buffer stays
// not-ready for the cycle in which it dequeues.
//
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   wr_valid_i/wr_ready_o        : request handshake
//   wr_addr_i/wr_data_i          : request payload (addr 0 is consumed, not stored)
//   rf_stall_i                   : register file write port busy; freezes drain
//   rf_we_o/rf_addr_o/rf_data_o  : register file write port (head entry)
//   rs_*/rt_*                    : bypass lookups (hit + newest pending data)
//   count_o                      : number of valid entries
module rf_write_buffer
  import rf_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     rf_stall_i,
  output logic                     rf_we_o,
  output logic [AW-1:0]            rf_addr_o,
  output logic [DW-1:0]            rf_data_o,
  input  logic [AW-1:0]            rs_addr_i,
  output logic                     rs_hit_o,
  output logic [DW-1:0]            rs_data_o,
  input  logic [AW-1:0]            rt_addr_i,
  output logic                     rt_hit_o,
  output logic [DW-1:0]            rt_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        entries_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;

  logic accept, enq, deq, not_empty;

  assign not_empty  = (count_q != '0);
  assign wr_ready_o = (count_q < CW'(DEPTH));
  assign accept     = wr_valid_i && wr_ready_o;
  // Writes to the zero register complete the handshake but never occupy a slot.
  assign enq        = accept && (wr_addr_i != REG_ZERO);
  assign rf_we_o    = not_empty && !rf_stall_i;
  assign deq        = rf_we_o;
  assign rf_addr_o  = not_empty ? entries_q[head_q].addr : '0;
  assign rf_data_o  = not_empty ? entries_q[head_q].data : '0;
  assign count_o    = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      // Enqueue and dequeue never target the same slot: a dequeue needs
      // count>0 and an enqueue needs count<DEPTH, so head != tail whenever both fire.
      if (enq) begin
        entries_q[tail_q] <= '{addr: wr_addr_i, data: wr_data_i};
        valid_q[tail_q]   <= 1'b1;
        tail_q            <= tail_q + 1'b1;
      end
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  rf_wb_match #(.DEPTH(DEPTH)) u_match_rs (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .tail_i    (tail_q),
    .addr_i    (rs_addr_i),
    .hit_o     (rs_hit_o),
    .data_o    (rs_data_o)
  );

  rf_wb_match #(.DEPTH(DEPTH)) u_match_rt (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .tail_i    (tail_q),
    .addr_i    (rt_addr_i),
    .hit_o     (rt_hit_o),
    .data_o    (rt_data_o)
  );

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed testbench for rf_write_buffer (DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_rf_write_buffer;
  import rf_write_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            wr_valid_i = 1'b0;
  logic            wr_ready_o;
  logic [AW-1:0]   wr_addr_i = '0;
  logic [DW-1:0]   wr_data_i = '0;
  logic            rf_stall_i = 1'b0;
  logic            rf_we_o;
  logic [AW-1:0]   rf_addr_o;
  logic [DW-1:0]   rf_data_o;
  logic [AW-1:0]   rs_addr_i = '0;
  logic            rs_hit_o;
  logic [DW-1:0]   rs_data_o;
  logic [AW-1:0]   rt_addr_i = '0;
  logic            rt_hit_o;
  logic [DW-1:0]   rt_data_o;
  logic [2:0]      count_o;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  rf_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rf_stall_i (rf_stall_i),
    .rf_we_o    (rf_we_o),
    .rf_addr_o  (rf_addr_o),
    .rf_data_o  (rf_data_o),
    .rs_addr_i  (rs_addr_i),
    .rs_hit_o   (rs_hit_o),
    .rs_data_o  (rs_data_o),
    .rt_addr_i  (rt_addr_i),
    .rt_hit_o   (rt_hit_o),
    .rt_data_o  (rt_data_o),
    .count_o    (count_o)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_wr(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid_i = v;
    wr_addr_i  = a;
    wr_data_i  = d;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    chk({tag, "_we"},   32'(rf_we_o),   32'(we));
    chk({tag, "_addr"}, 32'(rf_addr_o), 32'(a));
    chk({tag, "_data"}, rf_data_o,      d);
  endtask

  logic [DW-1:0] exp_d;

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #2;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_ready", 32'(wr_ready_o), 1);
    chk_port("rst", 1'b0, '0, '0);
    chk("rst_rs_hit", 32'(rs_hit_o), 0);
    chk("rst_rs_data", rs_data_o, 0);
    #1 rst_i = 1'b0;

    // Single write to empty buffer
    step();
    drive_wr(1'b1, 5'd3, 32'h1234_5678);
    rs_addr_i = 5'd3;
    #1;
    chk("single_noforward", 32'(rs_hit_o), 0);
    chk("single_ready", 32'(wr_ready_o), 1);
    step();
    drive_wr(1'b0, '0, '0);
    #1;
    chk("single_count1", 32'(count_o), 1);
    chk_port("single_drain", 1'b1, 5'd3, 32'h1234_5678);
    chk("single_rs_hit", 32'(rs_hit_o), 1);
    chk("single_rs_data", rs_data_o, 32'h1234_5678);
    step();
    chk("single_count0", 32'(count_o), 0);
    chk("single_we0", 32'(rf_we_o), 0);
    chk("single_rs_miss", 32'(rs_hit_o), 0);

    // $zero filter
    drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    rs_addr_i = 5'd0;
    #1;
    chk("zero_ready", 32'(wr_ready_o), 1);
    step();
    drive_wr(1'b0, '0, '0);
    #1;
    chk("zero_count", 32'(count_o), 0);
    chk("zero_we", 32'(rf_we_o), 0);
    chk("zero_rs_hit", 32'(rs_hit_o), 0);

    // Fill under stall
    rf_stall_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_wr(1'b1, 5'(i), 32'(9 + i));
      step();
    end
    drive_wr(1'b1, 5'd5, 32'd14);
    #1;
    chk("fill_count", 32'(count_o), 4);
    chk("fill_ready", 32'(wr_ready_o), 0);
    chk("fill_stall_we", 32'(rf_we_o), 0);
    rs_addr_i = 5'd2;
    rt_addr_i = 5'd4;
    #1;
    chk("fill_rs_data", rs_data_o, 32'd11);
    chk("fill_rt_data", rt_data_o, 32'd13);
    step();
    chk("fill_held_count", 32'(count_o), 4);
    // Release: fifth request still offered
    rf_stall_i = 1'b0;
    #1;
    chk_port("drain1", 1'b1, 5'd1, 32'd10);
    chk("drain1_ready", 32'(wr_ready_o), 0);
    step();
    chk_port("drain2", 1'b1, 5'd2, 32'd11);
    chk("drain2_ready", 32'(wr_ready_o), 1);
    chk("drain2_count", 32'(count_o), 3);
    step();
    drive_wr(1'b0, '0, '0);
    #1;
    chk("drain3_count", 32'(count_o), 3);
    chk_port("drain3", 1'b1, 5'd3, 32'd12);
    step();
    chk_port("drain4", 1'b1, 5'd4, 32'd13);
    step();
    chk_port("drain5", 1'b1, 5'd5, 32'd14);
    chk("drain5_count", 32'(count_o), 1);
    step();
    chk("drain_done_count", 32'(count_o), 0);
    chk("drain_done_we", 32'(rf_we_o), 0);

    // Duplicate bypass
    rf_stall_i = 1'b1;
    drive_wr(1'b1, 5'd7, 32'hA);
    step();
    drive_wr(1'b1, 5'd7, 32'hB);
    step();
    drive_wr(1'b0, '0, '0);
    rt_addr_i = 5'd7;
    rs_addr_i = 5'd6;
    #1;
    chk("dup_count", 32'(count_o), 2);
    chk("dup_rt_hit", 32'(rt_hit_o), 1);
    chk("dup_rt_data", rt_data_o, 32'hB);
    chk("dup_rs_miss", 32'(rs_hit_o), 0);
    rf_stall_i = 1'b0;
    #1;
    chk_port("dup_first", 1'b1, 5'd7, 32'hA);
    step();
    chk_port("dup_second", 1'b1, 5'd7, 32'hB);
    chk("dup_rt_data_after", rt_data_o, 32'hB);
    step();
    chk("dup_done_count", 32'(count_o), 0);

    // Wrap-around: simultaneous enqueue/dequeue for 10 cycles
    drive_wr(1'b1, 5'd8, 32'd100);
    exp_d = 32'd100;
    step();
    for (int i = 0; i < 10; i++) begin
      drive_wr(1'b1, 5'(9 + i), 32'(200 + i));
      #1;
      chk($sformatf("wrap%0d_count", i), 32'(count_o), 1);
      chk($sformatf("wrap%0d_data", i), rf_data_o, exp_d);
      chk($sformatf("wrap%0d_we", i), 32'(rf_we_o), 1);
      exp_d = 32'(200 + i);
      step();
    end
    drive_wr(1'b0, '0, '0);
    #1;
    chk_port("wrap_last", 1'b1, 5'd18, exp_d);
    step();
    chk("wrap_done_count", 32'(count_o), 0);

    // Reset mid-stream with 3 pending entries
    rf_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_wr(1'b1, 5'(10 + i), 32'(300 + i));
      step();
    end
    drive_wr(1'b0, '0, '0);
    rs_addr_i = 5'd10;
    #1;
    chk("mid_pre_count", 32'(count_o), 3);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count_o), 0);
    chk("mid_rst_we", 32'(rf_we_o), 0);
    chk("mid_rst_ready", 32'(wr_ready_o), 1);
    chk("mid_rst_rs_hit", 32'(rs_hit_o), 0);
    rf_stall_i = 1'b0;
    #1 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_post%0d_we", i), 32'(rf_we_o), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
